// File: rtl/ccff_pkg.sv
// Shared FSM state type and sizing helpers for the ccff chain loader.
package ccff_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHIFT,
        FINISH
    } ccff_state_t;

    // Bitstream words needed to cover the whole chain.
    function automatic int ccff_word_count(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    // Counter width able to hold chain_len itself without wrapping.
    function automatic int ccff_cnt_width(input int chain_len);
        return $clog2(chain_len + 1);
    endfunction

    function automatic int ccff_idx_width(input int word_w);
        return (word_w > 1) ? $clog2(word_w) : 1;
    endfunction

endpackage

// File: rtl/ccff_serializer.sv
// Word-to-bit serializer: holds the current word and tracks chain/word bit position.
// Latency: load and shift take effect on the next prog_clk edge.
// Backpressure: none here; the loader FSM decides when to load or shift.
module ccff_serializer
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 20,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = ccff_cnt_width(CHAIN_LEN),
    parameter int IDX_W     = ccff_idx_width(WORD_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic              shift,
    output logic              head_bit,
    output logic [IDX_W-1:0]  word_bit,
    output logic              word_end,
    output logic              chain_end
);

    logic [WORD_W-1:0] sreg;
    logic [CNT_W-1:0]  bit_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg     <= '0;
            bit_cnt  <= '0;
            word_bit <= '0;
        end else begin
            if (clear) begin
                bit_cnt <= '0;
            end else if (shift) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end

            if (load) begin
                sreg     <= load_data;
                word_bit <= '0;
            end else if (shift) begin
                sreg     <= sreg >> 1;
                word_bit <= word_bit + IDX_W'(1);
            end
        end
    end

    assign head_bit  = sreg[0];
    assign word_end  = (word_bit == IDX_W'(WORD_W - 1));
    // Sampled before the increment, so this flags the bit that brings bit_cnt to CHAIN_LEN.
    assign chain_end = (bit_cnt == CNT_W'(CHAIN_LEN - 1));

endmodule

// File: rtl/ccff_loader.sv
// Loads a bitstream word stream serially into a ccff chain (optional readback via CCFF_LOADER_READBACK_EN).
// Latency: CHAIN_LEN + ceil(CHAIN_LEN/WORD_W) + 1 cycles start->done with in_valid held (one more with readback).
// Backpressure: waits in FETCH for in_valid; with readback, an unaccepted rb word stalls shifting and done.
module ccff_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 20,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              ccff_head,
    output logic              shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done
`ifdef CCFF_LOADER_READBACK_EN
    ,
    output logic              rb_valid,
    input  logic              rb_ready,
    output logic [WORD_W-1:0] rb_data
`endif
);

    localparam int IDX_W = ccff_idx_width(WORD_W);

    ccff_state_t       state;
    ccff_state_t       state_nxt;
    logic              clear;
    logic              load;
    logic              shift;
    logic              hold;
    logic              head_bit;
    logic [IDX_W-1:0]  word_bit;
    logic              word_end;
    logic              chain_end;

`ifdef CCFF_LOADER_READBACK_EN
    logic [WORD_W-1:0] rb_sreg;

    // Chain words line up with readback words, so a pending rb word is always raised
    // at a word boundary; holding on rb_valid costs nothing when rb_ready is high.
    assign hold = rb_valid;
`else
    logic unused_readback;

    assign hold            = 1'b0;
    assign unused_readback = ^{ccff_tail, word_bit};
`endif

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear     = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (!hold) begin
                    shift = 1'b1;
                    if (chain_end) begin
                        state_nxt = FINISH;
                    end else if (word_end) begin
                        state_nxt = FETCH;
                    end
                end
            end
            FINISH: begin
                if (!hold) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs depend only on state and flops, never on in_valid/start/rb_ready.
    assign in_ready  = (state == FETCH);
    assign busy      = (state != IDLE);
    assign shift_en  = shift;
    assign ccff_head = shift & head_bit;
    assign done      = (state == FINISH) & ~hold;

    ccff_serializer #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W)
    ) u_serializer (
        .clk       (prog_clk),
        .rst       (prog_reset),
        .clear     (clear),
        .load      (load),
        .load_data (in_data),
        .shift     (shift),
        .head_bit  (head_bit),
        .word_bit  (word_bit),
        .word_end  (word_end),
        .chain_end (chain_end)
    );

`ifdef CCFF_LOADER_READBACK_EN
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            rb_sreg  <= '0;
            rb_valid <= 1'b0;
            rb_data  <= '0;
        end else begin
            if (rb_valid && rb_ready) begin
                rb_valid <= 1'b0;
            end
            if (shift) begin
                if (word_end || chain_end) begin
                    rb_data  <= rb_sreg | (WORD_W'(ccff_tail) << word_bit);
                    rb_valid <= 1'b1;
                    rb_sreg  <= '0;
                end else begin
                    rb_sreg[word_bit] <= ccff_tail;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_ccff_loader.sv
// Scoreboard bench for ccff_loader: chain model on the serial pins, expected bits/done/rb words queued at start.
module tb_ccff_loader;
    import ccff_pkg::*;

    localparam int L  = 20;
    localparam int W  = 8;
    localparam int NW = ccff_word_count(L, W);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         ccff_head;
    logic         shift_en;
    logic         ccff_tail;
    logic         busy;
    logic         done;
`ifdef CCFF_LOADER_READBACK_EN
    logic         rb_valid;
    logic         rb_ready;
    logic [W-1:0] rb_data;
    bit           rb_stall_pending = 1'b0;
`endif

    logic [L-1:0] chain = '0;
    int           cyc_cnt = 0;
    int           checks = 0;
    int           errors = 0;
    int           shifts_seen = 0;
    int           hs_seen = 0;
    logic         exp_bits[$];
    int           exp_done[$];
    logic [W-1:0] exp_rb[$];
    logic         mon_bit;
    int           mon_cyc;
    logic [W-1:0] mon_rb;

    ccff_loader #(.CHAIN_LEN(L), .WORD_W(W)) dut (
        .prog_clk   (clk),
        .prog_reset (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .ccff_head  (ccff_head),
        .shift_en   (shift_en),
        .ccff_tail  (ccff_tail),
        .busy       (busy),
        .done       (done)
`ifdef CCFF_LOADER_READBACK_EN
        ,
        .rb_valid   (rb_valid),
        .rb_ready   (rb_ready),
        .rb_data    (rb_data)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Target chain: head enters position 0, tail is the oldest bit.
    assign ccff_tail = chain[L-1];
    always @(posedge clk) if (shift_en) chain <= {chain[L-2:0], ccff_head};

    always @(negedge clk) begin
        if (!rst) begin
            if (shift_en) begin
                shifts_seen++;
                checks++;
                if (exp_bits.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_shift at cycle %0d", cyc_cnt);
                end else begin
                    mon_bit = exp_bits.pop_front();
                    if (ccff_head !== mon_bit) begin
                        errors++;
                        $display("FAIL ccff_head at cycle %0d: got %0b expected %0b", cyc_cnt, ccff_head, mon_bit);
                    end
                end
            end
            if (in_ready) begin
                checks++;
                if (shift_en !== 1'b0) begin
                    errors++;
                    $display("FAIL shift_in_fetch at cycle %0d: shift_en %0b expected 0", cyc_cnt, shift_en);
                end
                if (in_valid) hs_seen++;
            end
            if (done) begin
                checks++;
                if (exp_done.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done at cycle %0d", cyc_cnt);
                end else begin
                    mon_cyc = exp_done.pop_front();
                    if (cyc_cnt != mon_cyc) begin
                        errors++;
                        $display("FAIL done_cycle: got %0d expected %0d", cyc_cnt, mon_cyc);
                    end
                end
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_at_done: got %0b expected 1", busy);
                end
            end
`ifdef CCFF_LOADER_READBACK_EN
            if (rb_valid && rb_ready) begin
                checks++;
                if (exp_rb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rb at cycle %0d: rb_data %0h", cyc_cnt, rb_data);
                end else begin
                    mon_rb = exp_rb.pop_front();
                    if (rb_data !== mon_rb) begin
                        errors++;
                        $display("FAIL rb_data: got %0h expected %0h", rb_data, mon_rb);
                    end
                end
            end
            if (rb_valid && !rb_ready) begin
                checks++;
                if (shift_en !== 1'b0) begin
                    errors++;
                    $display("FAIL rb_stall at cycle %0d: shift_en %0b expected 0", cyc_cnt, shift_en);
                end
            end
`endif
        end
    end

`ifdef CCFF_LOADER_READBACK_EN
    // Withholds rb_ready for four cycles once the first rb word of a flagged load appears.
    initial begin
        rb_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rb_stall_pending && rb_valid) begin
                rb_stall_pending = 1'b0;
                rb_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                rb_ready = 1'b1;
            end
        end
    end
`endif

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic flush_queues();
        exp_bits.delete();
        exp_done.delete();
        exp_rb.delete();
`ifdef CCFF_LOADER_READBACK_EN
        rb_stall_pending = 1'b0;
`endif
    endtask

    task automatic resync();
        in_valid = 1'b0;
        rst = 1'b1;
        cyc();
        flush_queues();
        rst = 1'b0;
        cyc();
    endtask

    task automatic run_load(input logic [W-1:0] words [NW], input int gaps [NW],
                            input int restart_k, input int abort_bits, input bit rb_stall);
        int c0, hs0, sh0, n, gap_sum, lat;
        logic [W-1:0] rw;
        c0 = cyc_cnt;
        hs0 = hs_seen;
        sh0 = shifts_seen;
        gap_sum = 0;
        for (int k = 0; k < NW; k++) gap_sum += gaps[k];
        for (int i = 0; i < L; i++) exp_bits.push_back(words[i / W][i % W]);
        lat = L + NW + 1 + gap_sum;
`ifdef CCFF_LOADER_READBACK_EN
        // Old chain contents come back tail-first, i.e. in the order they were loaded.
        for (int j = 0; j < NW; j++) begin
            rw = '0;
            for (int b = 0; b < W; b++)
                if (j * W + b < L) rw[b] = chain[L - 1 - (j * W + b)];
            exp_rb.push_back(rw);
        end
        lat += 1 + (rb_stall ? 4 : 0);
        rb_stall_pending = rb_stall;
`else
        rw = '0;
        if (rb_stall) lat += 0;
`endif
        exp_done.push_back(c0 + lat);
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < NW; k++) begin
            n = 0;
            while (!in_ready && n < 100) begin
                cyc();
                n++;
            end
            if (!in_ready) begin
                errors++;
                $display("FAIL in_ready_timeout: got 0 expected 1 for word %0d", k);
                resync();
                return;
            end
            repeat (gaps[k]) cyc();
            in_valid = 1'b1;
            in_data = words[k];
            cyc();
            in_valid = 1'b0;
            in_data = W'($urandom);
            if (abort_bits >= 0 && abort_bits / W == k) begin
                repeat (abort_bits % W) cyc();
                rst = 1'b1;
                cyc();
                check("abort_shift_en", int'(shift_en), 0);
                check("abort_busy", int'(busy), 0);
                check("abort_in_ready", int'(in_ready), 0);
                check("abort_done", int'(done), 0);
                flush_queues();
                rst = 1'b0;
                cyc();
                return;
            end
            if (restart_k == k) begin
                start = 1'b1;
                cyc();
                start = 1'b0;
            end
        end
        n = 0;
        while ((exp_done.size() != 0 || exp_rb.size() != 0) && n < 200) begin
            cyc();
            n++;
        end
        if (exp_done.size() != 0 || exp_rb.size() != 0) begin
            errors++;
            $display("FAIL done_timeout: pending done %0d rb %0d expected 0", exp_done.size(), exp_rb.size());
            resync();
            return;
        end
        cyc();
        check("words_per_load", hs_seen - hs0, NW);
        check("shifts_per_load", shifts_seen - sh0, L);
    endtask

    initial begin
        logic [W-1:0] img [NW];
        int gz [NW];
        int gg [NW];
        int rk, ab;

        rst = 1'b1;
        repeat (3) cyc();
        check("reset_in_ready", int'(in_ready), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_shift_en", int'(shift_en), 0);
        check("reset_ccff_head", int'(ccff_head), 0);
`ifdef CCFF_LOADER_READBACK_EN
        check("reset_rb_valid", int'(rb_valid), 0);
        check("reset_rb_data", int'(rb_data), 0);
`endif
        rst = 1'b0;
        cyc();

        img = '{8'hA5, 8'h3C, 8'hF7};
        gz  = '{0, 0, 0};
        gg  = '{0, 0, 5};
        run_load(img, gz, -1, -1, 1'b0);
        run_load(img, gg, -1, -1, 1'b0);
        run_load(img, gz, 0, -1, 1'b0);
        run_load(img, gz, -1, 10, 1'b0);
        run_load(img, gz, -1, -1, 1'b0);
`ifdef CCFF_LOADER_READBACK_EN
        run_load(img, gz, -1, -1, 1'b1);
`endif

        for (int t = 0; t < 24; t++) begin
            for (int k = 0; k < NW; k++) begin
                img[k] = W'($urandom);
                gg[k]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            end
            rk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NW - 1)) : -1;
            ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, L - 1)) : -1;
            repeat ($urandom_range(0, 3)) cyc();
            run_load(img, gg, rk, ab, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
